// File: rtl/sim_uart_agent_pkg.sv
// Shared types and helpers for the sim_uart_agent bench UART.
package sim_uart_agent_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    PAR   = 3'd3,
    STOP  = 3'd4
  } uart_state_e;

  // Clocks per bit, truncated
  function automatic int cpb(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  // Width of a down-counter holding 0..n-1
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sim_uart_fifo.sv
// Generic synchronous FIFO with wrap-bit pointers; a pop frees space for a same-cycle push.
module sim_uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level   = wr_ptr - rd_ptr;
  assign head    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/sim_uart_agent.sv
// Bidirectional bench UART agent with TX/RX FIFOs and sticky error flags.
// Define SIM_UART_AGENT_PARITY_EN to add an even-parity bit on both directions.
module sim_uart_agent
  import sim_uart_agent_pkg::*;
#(
  parameter int CLK_HZ    = 50000000,
  parameter int BAUD      = 115200,
  parameter int DATA_BITS = 8,
  parameter int TX_DEPTH  = 16,
  parameter int RX_DEPTH  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_BITS-1:0]        tx_data_i,
  input  logic                        tx_valid_i,
  output logic                        tx_ready_o,
  output logic                        tx_o,
  output logic                        tx_busy_o,
  input  logic                        rx_i,
  output logic [DATA_BITS-1:0]        rx_data_o,
  output logic                        rx_valid_o,
  input  logic                        rx_ready_i,
  output logic                        rx_frame_err_o,
  output logic                        rx_overflow_o,
  input  logic                        clr_err_i,
  output logic [$clog2(TX_DEPTH):0]   tx_level_o,
  output logic [$clog2(RX_DEPTH):0]   rx_level_o
);
  localparam int CPB = cpb(CLK_HZ, BAUD);
  localparam int CW  = cnt_w(CPB);
  localparam int BW  = cnt_w(DATA_BITS);
  localparam logic [CW-1:0] CNT_BIT   = CW'(CPB - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(CPB / 2 - 1);
  localparam logic [BW-1:0] BITS_LAST = BW'(DATA_BITS - 1);

  logic                 tx_push, tx_pop, tx_full, tx_empty, tx_load, tx_line;
  logic [DATA_BITS-1:0] tx_head, tx_shift;
  uart_state_e          tx_state;
  logic [CW-1:0]        tx_cnt;
  logic [BW-1:0]        tx_bits;
`ifdef SIM_UART_AGENT_PARITY_EN
  logic                 tx_par;
`endif

  assign tx_ready_o = !tx_full;
  assign tx_push    = tx_valid_i && !tx_full;
  assign tx_load    = !tx_empty && (tx_state == IDLE || (tx_state == STOP && tx_cnt == '0));
  assign tx_pop     = tx_load;
  assign tx_o       = tx_line;
  assign tx_busy_o  = (tx_state != IDLE) || !tx_empty;

  sim_uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .push_data(tx_data_i), .pop(tx_pop),
    .head(tx_head), .full(tx_full), .empty(tx_empty), .level(tx_level_o)
  );

  // TX frame sequencer; the line register updates on the same edge as the state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bits  <= '0;
      tx_line  <= 1'b1;
    end else if (tx_load) begin
      tx_state <= START;
      tx_cnt   <= CNT_BIT;
      tx_line  <= 1'b0;
    end else if (tx_state != IDLE && tx_cnt != '0) begin
      tx_cnt <= tx_cnt - CW'(1);
    end else begin
      tx_cnt <= CNT_BIT;
      case (tx_state)
        START: begin
          tx_state <= DATA;
          tx_bits  <= BITS_LAST;
          tx_line  <= tx_shift[0];
        end
        DATA: begin
          if (tx_bits != '0) begin
            tx_bits <= tx_bits - BW'(1);
            tx_line <= tx_shift[1];
          end else begin
`ifdef SIM_UART_AGENT_PARITY_EN
            tx_state <= PAR;
            tx_line  <= tx_par;
`else
            tx_state <= STOP;
            tx_line  <= 1'b1;
`endif
          end
        end
        PAR: begin
          tx_state <= STOP;
          tx_line  <= 1'b1;
        end
        default: begin
          tx_state <= IDLE;
          tx_line  <= 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (tx_load) tx_shift <= tx_head;
    else if (tx_state == DATA && tx_cnt == '0) tx_shift <= tx_shift >> 1;
  end

`ifdef SIM_UART_AGENT_PARITY_EN
  always_ff @(posedge clk) begin
    if (tx_load) tx_par <= ^tx_head;
  end
`endif

  logic                 rx_sync_p0, rx_sync_p1;
  logic                 rx_push, rx_pop, rx_full, rx_empty, rx_brk, rx_good;
  logic                 stop_eval, frame_evt, ovf_evt;
  logic [DATA_BITS-1:0] rx_head, rx_shift;
  uart_state_e          rx_state;
  logic [CW-1:0]        rx_cnt;
  logic [BW-1:0]        rx_bits;
`ifdef SIM_UART_AGENT_PARITY_EN
  logic                 rx_par_bad;
  assign rx_good = rx_sync_p1 && !rx_par_bad;
`else
  assign rx_good = rx_sync_p1;
`endif

  // Two-stage synchroniser on the incoming line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_sync_p0 <= 1'b1;
      rx_sync_p1 <= 1'b1;
    end else begin
      rx_sync_p0 <= rx_i;
      rx_sync_p1 <= rx_sync_p0;
    end
  end

  assign stop_eval = (rx_state == STOP) && !rx_brk && (rx_cnt == '0);
  assign rx_push   = stop_eval && rx_good;
  assign frame_evt = stop_eval && !rx_good;
  assign rx_pop    = rx_ready_i && !rx_empty;
  assign ovf_evt   = rx_push && rx_full && !rx_pop;
  assign rx_valid_o = !rx_empty;
  assign rx_data_o  = rx_empty ? '0 : rx_head;

  sim_uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .push_data(rx_shift), .pop(rx_pop),
    .head(rx_head), .full(rx_full), .empty(rx_empty), .level(rx_level_o)
  );

  // RX sampler; a low stop bit parks in STOP until the line returns high
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_state <= IDLE;
      rx_cnt   <= '0;
      rx_bits  <= '0;
      rx_brk   <= 1'b0;
    end else begin
      case (rx_state)
        IDLE: begin
          if (!rx_sync_p1) begin
            rx_state <= START;
            rx_cnt   <= CNT_HALF;
          end
        end
        START: begin
          if (rx_cnt != '0) rx_cnt <= rx_cnt - CW'(1);
          else if (rx_sync_p1) rx_state <= IDLE;
          else begin
            rx_state <= DATA;
            rx_cnt   <= CNT_BIT;
            rx_bits  <= BITS_LAST;
          end
        end
        DATA: begin
          if (rx_cnt != '0) rx_cnt <= rx_cnt - CW'(1);
          else begin
            rx_cnt <= CNT_BIT;
            if (rx_bits != '0) rx_bits <= rx_bits - BW'(1);
`ifdef SIM_UART_AGENT_PARITY_EN
            else rx_state <= PAR;
`else
            else rx_state <= STOP;
`endif
          end
        end
        PAR: begin
          if (rx_cnt != '0) rx_cnt <= rx_cnt - CW'(1);
          else begin
            rx_cnt   <= CNT_BIT;
            rx_state <= STOP;
          end
        end
        STOP: begin
          if (rx_brk) begin
            if (rx_sync_p1) begin
              rx_brk   <= 1'b0;
              rx_state <= IDLE;
            end
          end else if (rx_cnt != '0) rx_cnt <= rx_cnt - CW'(1);
          else if (rx_sync_p1) rx_state <= IDLE;
          else rx_brk <= 1'b1;
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rx_state == DATA && rx_cnt == '0) rx_shift <= {rx_sync_p1, rx_shift[DATA_BITS-1:1]};
  end

`ifdef SIM_UART_AGENT_PARITY_EN
  always_ff @(posedge clk) begin
    if (rx_state == PAR && rx_cnt == '0) rx_par_bad <= rx_sync_p1 != ^rx_shift;
  end
`endif

  // Sticky error flags; a new event beats a same-cycle clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_frame_err_o <= 1'b0;
      rx_overflow_o  <= 1'b0;
    end else begin
      if (frame_evt)      rx_frame_err_o <= 1'b1;
      else if (clr_err_i) rx_frame_err_o <= 1'b0;
      if (ovf_evt)        rx_overflow_o  <= 1'b1;
      else if (clr_err_i) rx_overflow_o  <= 1'b0;
    end
  end

endmodule
